// File: rtl/mips_pkg.sv
// Shared hazard-unit types: forwarding select codes, FSM state encoding and small helpers.
package mips_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        WAIT = 2'b01,
        HALT = 2'b10
    } hz_state_t;

    // True when a nonzero destination register feeds the given source register.
    function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] val);
        return (val == 32'hFFFF_FFFF) ? val : (val + 32'd1);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// EX operand forwarding select for one source register; MEM result beats WB result.
module hazard_fwd_sel
    import mips_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic       reg_write_m_i,
    input  logic [4:0] write_reg_m_i,
    input  logic       reg_write_w_i,
    input  logic [4:0] write_reg_w_i,
    output logic [1:0] fwd_o
);

    // Select the youngest in-flight producer of rs_i; r0 is never forwarded.
    always_comb begin
        fwd_o = FWD_RF;
        if (reg_write_m_i && reg_match(write_reg_m_i, rs_i)) begin
            fwd_o = FWD_MEM;
        end else if (reg_write_w_i && reg_match(write_reg_w_i, rs_i)) begin
            fwd_o = FWD_WB;
        end else begin
            fwd_o = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// 5-stage MIPS hazard controller: stalls, flushes, forwarding and data-memory wait/timeout FSM.
// Optional saturating performance counters are built when HAZARD_PERF_EN is defined.
module hazard_unit
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [4:0] Ra_D,
    input  logic [4:0] Rb_D,
    input  logic       Branch_D,
    input  logic       BranchTaken_D,
    input  logic [4:0] Ra_E,
    input  logic [4:0] Rb_E,
    input  logic [4:0] WriteReg_E,
    input  logic       RegWrite_E,
    input  logic       MemRead_E,
    input  logic [4:0] WriteReg_M,
    input  logic       RegWrite_M,
    input  logic       MemRead_M,
    input  logic       MemWrite_M,
    input  logic [4:0] WriteReg_W,
    input  logic       RegWrite_W,
    input  logic       mem_ready,
    output logic       stall_F,
    output logic       stall_D,
    output logic       stall_E,
    output logic       stall_M,
    output logic       clr_D,
    output logic       clr_E,
    output logic [1:0] fwdA_E,
    output logic [1:0] fwdB_E,
    output logic       mem_err
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush,
    output logic [31:0] perf_wait
`endif
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    hz_state_t       state_q, state_d;
    logic [CW-1:0]   wcnt_q, wcnt_d;
    logic            mem_err_q, mem_err_d;
    logic            mw_s, lu_s, bh_s;
    logic [1:0]      fwd_a_s, fwd_b_s;

    hazard_fwd_sel u_fwd_a (
        .rs_i          (Ra_E),
        .reg_write_m_i (RegWrite_M),
        .write_reg_m_i (WriteReg_M),
        .reg_write_w_i (RegWrite_W),
        .write_reg_w_i (WriteReg_W),
        .fwd_o         (fwd_a_s)
    );

    hazard_fwd_sel u_fwd_b (
        .rs_i          (Rb_E),
        .reg_write_m_i (RegWrite_M),
        .write_reg_m_i (WriteReg_M),
        .reg_write_w_i (RegWrite_W),
        .write_reg_w_i (WriteReg_W),
        .fwd_o         (fwd_b_s)
    );

    assign mw_s = (MemRead_M || MemWrite_M) && !mem_ready;
    assign lu_s = MemRead_E && (reg_match(WriteReg_E, Ra_D) || reg_match(WriteReg_E, Rb_D));
    // A branch resolving in ID needs its operands now; EX results and MEM loads are not yet forwardable.
    assign bh_s = Branch_D &&
                  ((RegWrite_E && (reg_match(WriteReg_E, Ra_D) || reg_match(WriteReg_E, Rb_D))) ||
                   (MemRead_M  && (reg_match(WriteReg_M, Ra_D) || reg_match(WriteReg_M, Rb_D))));

    // Wait/timeout state, cycle counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= RUN;
            wcnt_q    <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    // Next-state logic; wcnt holds the number of wait cycles already elapsed.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        mem_err_d = mem_err_q;
        case (state_q)
            RUN: begin
                if (mw_s) begin
                    state_d = WAIT;
                    wcnt_d  = CW'(1);
                end else begin
                    state_d = RUN;
                end
            end
            WAIT: begin
                if (!mw_s) begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end else if (wcnt_q == CW'(MEM_TIMEOUT)) begin
                    state_d   = HALT;
                    mem_err_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + CW'(1);
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = RUN;
                wcnt_d  = '0;
            end
        endcase
    end

    // Prioritised stall/flush controls; forwarding stays live through stalls.
    always_comb begin
        stall_F = 1'b0;
        stall_D = 1'b0;
        stall_E = 1'b0;
        stall_M = 1'b0;
        clr_D   = 1'b0;
        clr_E   = 1'b0;
        fwdA_E  = fwd_a_s;
        fwdB_E  = fwd_b_s;
        if (clr) begin
            clr_D  = 1'b1;
            clr_E  = 1'b1;
            fwdA_E = FWD_RF;
            fwdB_E = FWD_RF;
        end else if ((state_q == HALT) || mw_s) begin
            {stall_F, stall_D, stall_E, stall_M} = 4'b1111;
        end else if (lu_s || bh_s) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            clr_E   = 1'b1;
        end else if (Branch_D && BranchTaken_D) begin
            clr_D = 1'b1;
        end else begin
            clr_D = 1'b0;
        end
    end

    assign mem_err = mem_err_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_flush_q, perf_wait_q;
    logic        stall_ev_s, flush_ev_s, wait_ev_s;

    // Only the load-use/branch-hazard bubble raises stall_F together with clr_E.
    assign stall_ev_s = stall_F && clr_E;
    assign flush_ev_s = clr_D && !clr_E;
    assign wait_ev_s  = !clr && (state_q != HALT) && mw_s;

    // Saturating event counters, frozen while halted.
    always_ff @(posedge clk) begin
        if (clr) begin
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
            perf_wait_q  <= 32'd0;
        end else if (state_q != HALT) begin
            perf_stall_q <= stall_ev_s ? sat_inc(perf_stall_q) : perf_stall_q;
            perf_flush_q <= flush_ev_s ? sat_inc(perf_flush_q) : perf_flush_q;
            perf_wait_q  <= wait_ev_s  ? sat_inc(perf_wait_q)  : perf_wait_q;
        end else begin
            perf_stall_q <= perf_stall_q;
            perf_flush_q <= perf_flush_q;
            perf_wait_q  <= perf_wait_q;
        end
    end

    assign perf_stall = perf_stall_q;
    assign perf_flush = perf_flush_q;
    assign perf_wait  = perf_wait_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed vector table, multi-cycle sequences, random vs. reference model.
module tb_hazard_unit;

    localparam int T = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr;
    logic [4:0] Ra_D, Rb_D, Ra_E, Rb_E, WriteReg_E, WriteReg_M, WriteReg_W;
    logic       Branch_D, BranchTaken_D, RegWrite_E, MemRead_E;
    logic       RegWrite_M, MemRead_M, MemWrite_M, RegWrite_W, mem_ready;
    logic       stall_F, stall_D, stall_E, stall_M, clr_D, clr_E, mem_err;
    logic [1:0] fwdA_E, fwdB_E;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall, perf_flush, perf_wait;
`endif

    hazard_unit #(.MEM_TIMEOUT(T)) dut (
        .clk(clk), .clr(clr),
        .Ra_D(Ra_D), .Rb_D(Rb_D), .Branch_D(Branch_D), .BranchTaken_D(BranchTaken_D),
        .Ra_E(Ra_E), .Rb_E(Rb_E), .WriteReg_E(WriteReg_E), .RegWrite_E(RegWrite_E), .MemRead_E(MemRead_E),
        .WriteReg_M(WriteReg_M), .RegWrite_M(RegWrite_M), .MemRead_M(MemRead_M), .MemWrite_M(MemWrite_M),
        .WriteReg_W(WriteReg_W), .RegWrite_W(RegWrite_W), .mem_ready(mem_ready),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
        .clr_D(clr_D), .clr_E(clr_E), .fwdA_E(fwdA_E), .fwdB_E(fwdB_E), .mem_err(mem_err)
`ifdef HAZARD_PERF_EN
        , .perf_stall(perf_stall), .perf_flush(perf_flush), .perf_wait(perf_wait)
`endif
    );

    typedef struct {
        logic [4:0] ra_d, rb_d;
        logic       br, bt;
        logic [4:0] ra_e, rb_e, wr_e;
        logic       rw_e, mr_e;
        logic [4:0] wr_m;
        logic       rw_m, mr_m, mw_m;
        logic [4:0] wr_w;
        logic       rw_w, rdy;
        logic [3:0] e_stall;
        logic       e_cd, e_ce;
        logic [1:0] e_fa, e_fb;
    } vec_t;

    int checks = 0;
    int failures = 0;

    bit m_halt = 1'b0;
    int m_streak = 0;
    bit m_err = 1'b0;
    int p_stall = 0, p_flush = 0, p_wait = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic zero_in();
        clr = 1'b0; Ra_D = 5'd0; Rb_D = 5'd0; Branch_D = 1'b0; BranchTaken_D = 1'b0;
        Ra_E = 5'd0; Rb_E = 5'd0; WriteReg_E = 5'd0; RegWrite_E = 1'b0; MemRead_E = 1'b0;
        WriteReg_M = 5'd0; RegWrite_M = 1'b0; MemRead_M = 1'b0; MemWrite_M = 1'b0;
        WriteReg_W = 5'd0; RegWrite_W = 1'b0; mem_ready = 1'b1;
    endtask

    function automatic logic [10:0] exp_v(input logic [3:0] st, input logic cd, input logic ce,
                                          input logic [1:0] fa, input logic [1:0] fb, input logic err);
        return {st, cd, ce, fa, fb, err};
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] rx);
        if (rx != 5'd0 && RegWrite_M && WriteReg_M == rx) return 2'b10;
        if (rx != 5'd0 && RegWrite_W && WriteReg_W == rx) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit ref_mw();
        return (MemRead_M || MemWrite_M) && !mem_ready;
    endfunction

    function automatic bit ref_hold();
        bit lu, bh, dep_e, dep_m;
        lu    = MemRead_E && WriteReg_E != 5'd0 && (WriteReg_E == Ra_D || WriteReg_E == Rb_D);
        dep_e = RegWrite_E && WriteReg_E != 5'd0 && (WriteReg_E == Ra_D || WriteReg_E == Rb_D);
        dep_m = MemRead_M && WriteReg_M != 5'd0 && (WriteReg_M == Ra_D || WriteReg_M == Rb_D);
        bh    = Branch_D && (dep_e || dep_m);
        return lu || bh;
    endfunction

    function automatic logic [10:0] ref_out();
        logic [1:0] fa, fb;
        fa = ref_fwd(Ra_E);
        fb = ref_fwd(Rb_E);
        if (clr) return exp_v(4'b0000, 1'b1, 1'b1, 2'b00, 2'b00, m_err);
        if (m_halt || ref_mw()) return exp_v(4'b1111, 1'b0, 1'b0, fa, fb, m_err);
        if (ref_hold()) return exp_v(4'b1100, 1'b0, 1'b1, fa, fb, m_err);
        if (Branch_D && BranchTaken_D) return exp_v(4'b0000, 1'b1, 1'b0, fa, fb, m_err);
        return exp_v(4'b0000, 1'b0, 1'b0, fa, fb, m_err);
    endfunction

    // Advance the reference model across the coming clock edge.
    task automatic model_step();
        if (clr) begin
            m_halt = 1'b0; m_streak = 0; m_err = 1'b0;
            p_stall = 0; p_flush = 0; p_wait = 0;
        end else if (!m_halt) begin
            if (ref_mw()) p_wait++;
            else if (ref_hold()) p_stall++;
            else if (Branch_D && BranchTaken_D) p_flush++;
            if (ref_mw()) begin
                if (m_streak == T) begin
                    m_halt = 1'b1;
                    m_err  = 1'b1;
                end else begin
                    m_streak++;
                end
            end else begin
                m_streak = 0;
            end
        end
    endtask

    task automatic check_now(input string name, input logic [10:0] exp);
        #2;
        chk(name, {21'd0, stall_F, stall_D, stall_E, stall_M, clr_D, clr_E, fwdA_E, fwdB_E, mem_err},
            {21'd0, exp});
        model_step();
    endtask

    task automatic apply_vec(input vec_t v);
        zero_in();
        Ra_D = v.ra_d; Rb_D = v.rb_d; Branch_D = v.br; BranchTaken_D = v.bt;
        Ra_E = v.ra_e; Rb_E = v.rb_e; WriteReg_E = v.wr_e; RegWrite_E = v.rw_e; MemRead_E = v.mr_e;
        WriteReg_M = v.wr_m; RegWrite_M = v.rw_m; MemRead_M = v.mr_m; MemWrite_M = v.mw_m;
        WriteReg_W = v.wr_w; RegWrite_W = v.rw_w; mem_ready = v.rdy;
    endtask

    vec_t tab[14];

    initial begin
        // ra_d rb_d br bt | ra_e rb_e wr_e rw_e mr_e | wr_m rw_m mr_m mw_m | wr_w rw_w rdy | stall cd ce fa fb
        tab[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 2'b10, 2'b00};
        tab[1]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00};
        tab[2]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 2'b01, 2'b01};
        tab[3]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b01};
        tab[4]  = '{5'd0, 5'd8, 1'b0, 1'b0, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 4'b1100, 1'b0, 1'b1, 2'b00, 2'b00};
        tab[5]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00};
        tab[6]  = '{5'd3, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 2'b00, 2'b00};
        tab[7]  = '{5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00};
        tab[8]  = '{5'd3, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 4'b1100, 1'b0, 1'b1, 2'b00, 2'b00};
        tab[9]  = '{5'd0, 5'd4, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 4'b1100, 1'b0, 1'b1, 2'b00, 2'b00};
        tab[10] = '{5'd3, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00};
        tab[11] = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 2'b00, 2'b00};
        tab[12] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 2'b10, 2'b10};
        tab[13] = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 2'b00, 2'b00};

        // Reset: clr wins over forwarding; mem_err comes up cleared.
        zero_in();
        clr = 1'b1; Ra_E = 5'd5; RegWrite_M = 1'b1; WriteReg_M = 5'd5; Branch_D = 1'b1;
        @(negedge clk);
        check_now("reset_out", exp_v(4'b0000, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0));

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            apply_vec(tab[i]);
            check_now($sformatf("vec%0d", i),
                      {tab[i].e_stall, tab[i].e_cd, tab[i].e_ce, tab[i].e_fa, tab[i].e_fb, 1'b0});
        end

        // Load-use: one bubble, then the dependent instruction forwards from WB.
        @(negedge clk); zero_in();
        MemRead_E = 1'b1; RegWrite_E = 1'b1; WriteReg_E = 5'd8; Rb_D = 5'd8;
        check_now("lu_bubble", exp_v(4'b1100, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0));
        @(negedge clk); zero_in();
        MemRead_M = 1'b1; RegWrite_M = 1'b1; WriteReg_M = 5'd8; Rb_D = 5'd8;
        check_now("lu_release", exp_v(4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
        @(negedge clk); zero_in();
        RegWrite_W = 1'b1; WriteReg_W = 5'd8; Rb_E = 5'd8;
        check_now("lu_fwd_wb", exp_v(4'b0000, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0));

        // Taken branch with an EX dependency: stall first, flush once the hazard clears.
        @(negedge clk); zero_in();
        Branch_D = 1'b1; BranchTaken_D = 1'b1; Ra_D = 5'd3; RegWrite_E = 1'b1; WriteReg_E = 5'd3;
        check_now("bh_stall", exp_v(4'b1100, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0));
        @(negedge clk); zero_in();
        Branch_D = 1'b1; BranchTaken_D = 1'b1; Ra_D = 5'd3; RegWrite_M = 1'b1; WriteReg_M = 5'd3;
        check_now("bh_flush", exp_v(4'b0000, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0));

        // Three-cycle memory wait overrides load-use and branch flush, then a back-to-back wait.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); zero_in();
            MemRead_M = 1'b1; mem_ready = 1'b0;
            MemRead_E = 1'b1; WriteReg_E = 5'd2; Ra_D = 5'd2; Branch_D = 1'b1; BranchTaken_D = 1'b1;
            check_now("mw_freeze", exp_v(4'b1111, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
        end
        @(negedge clk); zero_in();
        MemRead_M = 1'b1;
        check_now("mw_done", exp_v(4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));

        // Timeout: T+1 consecutive wait cycles reach HALT, which holds until clr.
        for (int i = 0; i <= T; i++) begin
            @(negedge clk); zero_in();
            MemWrite_M = 1'b1; mem_ready = 1'b0;
            check_now($sformatf("to_wait%0d", i), exp_v(4'b1111, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
        end
        @(negedge clk); zero_in();
        check_now("halt_hold", exp_v(4'b1111, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1));
        @(negedge clk); zero_in();
        Ra_E = 5'd5; RegWrite_W = 1'b1; WriteReg_W = 5'd5;
        check_now("halt_fwd", exp_v(4'b1111, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1));
        @(negedge clk); zero_in();
        clr = 1'b1;
        check_now("halt_clr", exp_v(4'b0000, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1));
        @(negedge clk); zero_in();
        check_now("post_clr", exp_v(4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));

`ifdef HAZARD_PERF_EN
        // Two load-use bubbles, one taken branch and a three-cycle wait.
        @(negedge clk); zero_in(); clr = 1'b1; check_now("perf_clr", ref_out());
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); zero_in();
            MemRead_E = 1'b1; WriteReg_E = 5'd4; Ra_D = 5'd4;
            check_now("perf_lu", exp_v(4'b1100, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0));
            @(negedge clk); zero_in(); check_now("perf_gap", exp_v(4'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
        end
        @(negedge clk); zero_in(); Branch_D = 1'b1; BranchTaken_D = 1'b1;
        check_now("perf_br", exp_v(4'b0000, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); zero_in(); MemRead_M = 1'b1; mem_ready = 1'b0;
            check_now("perf_mw", exp_v(4'b1111, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
        end
        @(negedge clk); zero_in(); #2;
        chk("perf_stall_cnt", perf_stall, 32'd2);
        chk("perf_flush_cnt", perf_flush, 32'd1);
        chk("perf_wait_cnt", perf_wait, 32'd3);
        model_step();
`endif

        // Randomized traffic against the reference model.
        @(negedge clk); zero_in(); clr = 1'b1; check_now("rnd_clr", ref_out());
        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            clr           = ($urandom_range(0, 49) == 0);
            Ra_D          = 5'($urandom_range(0, 3));
            Rb_D          = 5'($urandom_range(0, 3));
            Branch_D      = 1'($urandom_range(0, 1));
            BranchTaken_D = 1'($urandom_range(0, 1));
            Ra_E          = 5'($urandom_range(0, 3));
            Rb_E          = 5'($urandom_range(0, 3));
            WriteReg_E    = 5'($urandom_range(0, 3));
            RegWrite_E    = 1'($urandom_range(0, 1));
            MemRead_E     = ($urandom_range(0, 3) == 0);
            WriteReg_M    = 5'($urandom_range(0, 3));
            RegWrite_M    = 1'($urandom_range(0, 1));
            MemRead_M     = ($urandom_range(0, 2) == 0);
            MemWrite_M    = ($urandom_range(0, 3) == 0);
            WriteReg_W    = 5'($urandom_range(0, 3));
            RegWrite_W    = 1'($urandom_range(0, 1));
            mem_ready     = ($urandom_range(0, 9) < 5);
`ifdef HAZARD_PERF_EN
            #2;
            chk("rnd_perf_stall", perf_stall, p_stall);
            chk("rnd_perf_flush", perf_flush, p_flush);
            chk("rnd_perf_wait", perf_wait, p_wait);
            #1;
            check_now($sformatf("rnd%0d", n), ref_out());
`else
            check_now($sformatf("rnd%0d", n), ref_out());
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
